// File: rtl/uart_transmitter.sv
// ----------------------------------------------------------------------------
// uart_transmitter
//
// Serial UART transmitter. Words arrive through a valid/ready handshake into
// a one-entry holding register and are sent as a start bit, 8 data bits
// (LSB first), an optional parity bit and 1 or 2 stop bits. While a frame is
// being shifted out, the holding register can take the next word. That word
// is then sent immediately after the current stop bit(s), with no idle gap.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   PARITY_EN     1 = append a parity bit after the data bits
//   PARITY_ODD    1 = odd parity, 0 = even parity (only with PARITY_EN = 1)
//   STOP_BITS     number of stop bits, 1 or 2
//
// Ports
//   clk       in   system clock, rising edge
//   nRESET    in   asynchronous active-low reset
//   tx_data   in   [7:0] word to transmit, taken when tx_valid && tx_ready
//   tx_valid  in   requester has a word on tx_data
//   tx_ready  out  holding register empty (registered)
//   tx        out  serial line, idles high (registered)
//   tx_busy   out  a frame is being shifted out
//   tx_done   out  one-cycle pulse in the last cycle of each frame
// ----------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Parity bit for a word: XOR of the data bits, inverted for odd parity.
    function automatic logic f_parity(input logic [7:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    // Control state (reset)
    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic              r_hold_full;
    logic              r_tx;

    // Data path (no reset needed: only observed once loaded)
    logic [7:0]        r_hold;
    logic [7:0]        r_shift;
    logic              r_par;

    // Next-state values
    state_t            w_state_nxt;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        w_bit_nxt;
    logic [7:0]        w_shift_nxt;
    logic              w_load;
    logic              w_tx_nxt;
    logic              w_baud_last;
    logic              w_accept;

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_accept    = tx_valid && !r_hold_full;

    // ------------------------------------------------------------------
    // Next-state logic. w_load marks the edge that drains the holding
    // register into the shift register (leaving IDLE or the end of STOP).
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_baud_last ? '0 : r_baud + BAUD_W'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (r_hold_full) begin
                    w_state_nxt = S_START;
                    w_load      = 1'b1;
                end
            end

            S_START: begin
                if (w_baud_last) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end

            S_DATA: begin
                if (w_baud_last) begin
                    if (r_bit == 3'd7) begin
                        w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end
            end

            S_PARITY: begin
                if (w_baud_last) begin
                    w_state_nxt = S_STOP;
                    w_bit_nxt   = '0;
                end
            end

            S_STOP: begin
                if (w_baud_last) begin
                    if (r_bit == STOP_LAST) begin
                        w_bit_nxt = '0;
                        // A waiting word starts right away: no idle gap.
                        if (r_hold_full) begin
                            w_state_nxt = S_START;
                            w_load      = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
            end
        endcase

        if (w_load) begin
            w_shift_nxt = r_hold;
        end
    end

    // tx is registered from the next state, so the line changes on the
    // same edge as the state register and each bit lasts exactly
    // CLKS_PER_BIT cycles.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_IDLE:   w_tx_nxt = 1'b1;
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = r_par;
            S_STOP:   w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit       <= '0;
            r_hold_full <= 1'b0;
            r_tx        <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
            // Drain and accept never coincide: accept needs the hold empty,
            // drain needs it full. The earliest refill is the next edge.
            if (w_load) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold <= tx_data;
        end
        r_shift <= w_shift_nxt;
        if (w_load) begin
            r_par <= f_parity(r_hold);
        end
    end

    assign tx       = r_tx;
    assign tx_ready = !r_hold_full;
    assign tx_busy  = (r_state != S_IDLE);
    assign tx_done  = (r_state == S_STOP) && w_baud_last && (r_bit == STOP_LAST);

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

    localparam int CPB = 4;
    localparam int NI  = 3;
    // Instance 0: 8N1, instance 1: even parity, 2 stop, instance 2: odd parity, 1 stop
    localparam logic [2:0] PE_V  = 3'b110;
    localparam logic [2:0] PO_V  = 3'b100;
    localparam logic [2:0] SB2_V = 3'b010;

    logic       clk = 1'b0;
    logic       nRESET;
    logic       v    [NI];
    logic [7:0] d    [NI];
    logic       rdy  [NI];
    logic       txo  [NI];
    logic       busy [NI];
    logic       done [NI];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .nRESET(nRESET), .tx_data(d[0]), .tx_valid(v[0]),
        .tx_ready(rdy[0]), .tx(txo[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .clk(clk), .nRESET(nRESET), .tx_data(d[1]), .tx_valid(v[1]),
        .tx_ready(rdy[1]), .tx(txo[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .nRESET(nRESET), .tx_data(d[2]), .tx_valid(v[2]),
        .tx_ready(rdy[2]), .tx(txo[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level reference model
    // ------------------------------------------------------------------
    function automatic int flen(input int i);
        return (10 + int'(PE_V[i]) + (SB2_V[i] ? 2 : 1) - 1) * CPB;
    endfunction

    // Serial bit number idx of the frame carrying word w on instance i
    function automatic logic fbit(input int i, input logic [7:0] w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        if (idx == 9 && PE_V[i]) return (^w) ^ PO_V[i];
        return 1'b1;
    endfunction

    bit         m_hf   [NI];
    bit         m_in   [NI];
    int         m_cyc  [NI];
    logic [7:0] m_hold [NI];
    logic [7:0] m_word [NI];
    logic [7:0] exp_q  [$];   // words whose frames started on instance 0

    bit         t_hf, t_in, t_acc;
    int         t_cyc;
    logic [7:0] t_w;

    always @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < NI; i++) begin
                m_hf[i]  <= 1'b0;
                m_in[i]  <= 1'b0;
                m_cyc[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                t_hf  = m_hf[i];
                t_in  = m_in[i];
                t_cyc = m_cyc[i];
                t_w   = m_word[i];
                t_acc = v[i] && !m_hf[i];
                if (t_in) begin
                    t_cyc++;
                    if (t_cyc == flen(i)) begin
                        t_cyc = 0;
                        if (t_hf) begin
                            t_w  = m_hold[i];
                            t_hf = 1'b0;
                            if (i == 0) exp_q.push_back(t_w);
                        end else begin
                            t_in = 1'b0;
                        end
                    end
                end else if (t_hf) begin
                    t_in  = 1'b1;
                    t_cyc = 0;
                    t_w   = m_hold[i];
                    t_hf  = 1'b0;
                    if (i == 0) exp_q.push_back(t_w);
                end
                if (t_acc) begin
                    t_hf = 1'b1;
                    m_hold[i] <= d[i];
                end
                m_hf[i]   <= t_hf;
                m_in[i]   <= t_in;
                m_cyc[i]  <= t_cyc;
                m_word[i] <= t_w;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("tx%0d", i),    txo[i],  m_in[i] ? fbit(i, m_word[i], m_cyc[i] / CPB) : 1'b1);
            chk($sformatf("busy%0d", i),  busy[i], m_in[i]);
            chk($sformatf("done%0d", i),  done[i], m_in[i] && (m_cyc[i] == flen(i) - 1));
            chk($sformatf("ready%0d", i), rdy[i],  !m_hf[i]);
        end
    end

    // ------------------------------------------------------------------
    // Loopback receiver on instance 0 (8N1): mid-bit sampling
    // ------------------------------------------------------------------
    bit         rx_busy;
    int         rx_cnt;
    logic [7:0] rx_sh;
    logic [7:0] rx_log [$];

    always @(negedge clk or negedge nRESET) begin
        if (!nRESET) begin
            rx_busy <= 1'b0;
            rx_cnt  <= 0;
            exp_q.delete();
        end else if (!rx_busy) begin
            if (txo[0] == 1'b0) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt == 2) chk("rx_start", txo[0], 1'b0);
            for (int k = 1; k <= 8; k++)
                if (rx_cnt == 4 * k + 2) rx_sh[k-1] <= txo[0];
            if (rx_cnt == 38) begin
                chk("rx_stop", txo[0], 1'b1);
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected_frame", rx_sh, 8'hxx);
                end else begin
                    chk("rx_data", rx_sh, exp_q.pop_front());
                end
                rx_log.push_back(rx_sh);
                rx_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send(input int i, input logic [7:0] w);
        int n;
        v[i] = 1'b1;
        d[i] = w;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[i] && n < 3000);
        chk($sformatf("ready_wait%0d", i), rdy[i], 1'b1);
        if (!rdy[i]) begin
            v[i] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        v[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_stream(input int i, input int nw);
        int g;
        for (int k = 0; k < nw; k++) begin
            g = $urandom_range(0, 60);
            if (g > 0) idle(g);
            send(i, 8'($urandom));
        end
    endtask

    logic [63:0] cap      [NI];
    logic [63:0] cap_busy [NI];
    int          dn_idx   [NI];
    int          dn_cnt   [NI];
    logic [9:0]  pat;
    logic [39:0] expw;
    int          done_at  [2];
    int          ndone, lowcnt;

    initial begin
        #600000;
        n_fail++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET = 1'b0;
        for (int i = 0; i < NI; i++) begin
            v[i] = 1'b0;
            d[i] = 8'h00;
        end
        idle(3);
        chk("reset_tx", txo[0], 1'b1);
        chk("reset_ready", rdy[0], 1'b1);
        nRESET = 1'b1;
        idle(4);

        // Single frame 0xA5 on all instances: 8N1, 8E2, 8O1
        for (int i = 0; i < NI; i++) begin
            v[i] = 1'b1;
            d[i] = 8'hA5;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            v[i] = 1'b0;
            chk($sformatf("accept_ready%0d", i), rdy[i], 1'b0);
            dn_idx[i] = -1;
            dn_cnt[i] = 0;
        end
        @(negedge clk);
        chk("latency_still_idle", txo[0], 1'b1);
        for (int j = 0; j < 52; j++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                cap[i][j]      = txo[i];
                cap_busy[i][j] = busy[i];
                if (done[i]) begin
                    dn_cnt[i]++;
                    dn_idx[i] = j;
                end
            end
        end
        pat = 10'b1101001010;
        for (int j = 0; j < 40; j++) expw[j] = pat[j / 4];
        chk("a5_wave", cap[0][39:0], expw);
        chk("a5_done_idx", dn_idx[0], 39);
        chk("a5_done_cnt", dn_cnt[0], 1);
        chk("a5_idle_after", cap_busy[0][40], 1'b0);
        chk("even_data", cap[1][35:0], expw[35:0]);
        chk("even_parity_bit", cap[1][39:36], 4'h0);
        chk("stop2_high", cap[1][47:40], 8'hFF);
        chk("stop2_done_idx", dn_idx[1], 47);
        chk("odd_parity_bit", cap[2][39:36], 4'hF);
        chk("odd_stop_high", cap[2][43:40], 4'hF);
        chk("odd_done_idx", dn_idx[2], 43);
        idle(10);

        // Back-to-back: 0x0F offered while 0x55 is in flight
        send(0, 8'h55);
        idle(10);
        send(0, 8'h0F);
        chk("b2b_ready_low", rdy[0], 1'b0);
        ndone  = 0;
        lowcnt = 0;
        for (int j = 0; j < 120; j++) begin
            @(negedge clk);
            if (done[0] && ndone < 2) begin
                done_at[ndone] = j;
                ndone++;
            end
            if (!busy[0] && ndone < 2) lowcnt++;
        end
        chk("b2b_done_cnt", ndone, 2);
        chk("b2b_done_spacing", done_at[1] - done_at[0], 40);
        chk("b2b_no_gap", lowcnt, 0);
        idle(10);

        // Backpressure: three words with tx_valid held high
        rx_log.delete();
        send(0, 8'h11);
        send(0, 8'h22);
        send(0, 8'h33);
        idle(150);
        chk("bp_count", rx_log.size(), 3);
        if (rx_log.size() == 3) begin
            chk("bp_word0", rx_log[0], 8'h11);
            chk("bp_word1", rx_log[1], 8'h22);
            chk("bp_word2", rx_log[2], 8'h33);
        end

        // Loopback
        rx_log.delete();
        send(0, 8'h00);
        idle(3);
        send(0, 8'hFF);
        send(0, 8'h3C);
        idle(150);
        chk("lb_count", rx_log.size(), 3);
        if (rx_log.size() == 3) begin
            chk("lb_word0", rx_log[0], 8'h00);
            chk("lb_word1", rx_log[1], 8'hFF);
            chk("lb_word2", rx_log[2], 8'h3C);
        end

        // Reset in the middle of the data bits
        send(0, 8'h3C);
        repeat (14) @(negedge clk);
        chk("pre_reset_busy", busy[0], 1'b1);
        #1;
        nRESET = 1'b0;
        #1;
        chk("abort_tx", txo[0], 1'b1);
        chk("abort_busy", busy[0], 1'b0);
        chk("abort_ready", rdy[0], 1'b1);
        chk("abort_done", done[0], 1'b0);
        repeat (2) @(negedge clk);
        #1;
        nRESET = 1'b1;
        idle(60);

        // Randomised traffic on all instances
        fork
            rand_stream(0, 12);
            rand_stream(1, 12);
            rand_stream(2, 12);
        join
        idle(120);
        chk("loopback_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
